// File: rtl/mem_bus_arbiter.sv
// Arbitrates the fetch and MEM-stage ports onto one shared bus, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data wins ties.
module mem_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                bus_req,
  output logic                bus_wr,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,

  output logic                stallreq_for_bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t state;
  logic   grant_data;
  logic   pick_data;
  logic   addr_hit;
  logic   data_hit;

`ifdef ARB_RR_EN
  logic last_grant_data;

  // On a tie the requester that was not served last goes first.
  assign pick_data = data_req & (~inst_req | ~last_grant_data);
`else
  assign pick_data = data_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant_data <= 1'b0;
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_wstrb  <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
`ifdef ARB_RR_EN
      last_grant_data <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (inst_req | data_req) begin
            grant_data <= pick_data;
            bus_req    <= 1'b1;
            bus_wr     <= pick_data & data_wr;
            bus_wstrb  <= pick_data ? data_wstrb : '0;
            bus_addr   <= pick_data ? data_addr  : inst_addr;
            bus_wdata  <= pick_data ? data_wdata : '0;
            state      <= ADDR;
`ifdef ARB_RR_EN
            last_grant_data <= pick_data;
`endif
          end
        end
        ADDR: begin
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (bus_data_ok) begin
            state <= IDLE;
          end
        end
        default: begin
          bus_req <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // Handshake pulses are same-cycle echoes of the bus, suppressed while in reset.
  assign addr_hit = (state == ADDR) & bus_addr_ok & ~rst;
  assign data_hit = (state == DATA) & bus_data_ok & ~rst;

  assign inst_addr_ok = addr_hit & ~grant_data;
  assign data_addr_ok = addr_hit &  grant_data;
  assign inst_data_ok = data_hit & ~grant_data;
  assign data_data_ok = data_hit &  grant_data;

  assign inst_rdata = inst_data_ok ? bus_rdata : '0;
  assign data_rdata = data_data_ok ? bus_rdata : '0;

  assign stallreq_for_bus = (inst_req | data_req) & ~(inst_data_ok | data_data_ok);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [AW-1:0] inst_addr;
  logic          inst_addr_ok, inst_data_ok;
  logic [DW-1:0] inst_rdata;
  logic          data_req, data_wr;
  logic [SW-1:0] data_wstrb;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok, data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          bus_req, bus_wr;
  logic [SW-1:0] bus_wstrb;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_addr_ok, bus_data_ok;
  logic [DW-1:0] bus_rdata;
  logic          stallreq_for_bus;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
    .stallreq_for_bus(stallreq_for_bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: the one outstanding transaction (who = 1 means the data port owns it).
  bit            m_valid, m_acc, m_who, m_last, m_wr;
  logic [SW-1:0] m_wstrb;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  bit            e_inst_done, e_data_done;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output with the model, mid-cycle.
  task automatic settle();
    bit eb, e_ia, e_da;
    @(negedge clk);
    e_inst_done = 1'b0;
    e_data_done = 1'b0;
    if (!rst) begin
      eb          = m_valid && !m_acc;
      e_ia        = eb && bus_addr_ok && !m_who;
      e_da        = eb && bus_addr_ok &&  m_who;
      e_inst_done = m_valid && m_acc && bus_data_ok && !m_who;
      e_data_done = m_valid && m_acc && bus_data_ok &&  m_who;
      chk("bus_req", bus_req, eb);
      chk("inst_addr_ok", inst_addr_ok, e_ia);
      chk("data_addr_ok", data_addr_ok, e_da);
      chk("inst_data_ok", inst_data_ok, e_inst_done);
      chk("data_data_ok", data_data_ok, e_data_done);
      chk("inst_rdata", inst_rdata, e_inst_done ? bus_rdata : '0);
      chk("data_rdata", data_rdata, e_data_done ? bus_rdata : '0);
      chk("stallreq", stallreq_for_bus,
          (inst_req | data_req) & ~(e_inst_done | e_data_done));
      if (eb) begin
        chk("bus_addr", bus_addr, m_addr);
        chk("bus_wr", bus_wr, m_wr);
        chk("bus_wstrb", bus_wstrb, m_wstrb);
        if (m_wr) chk("bus_wdata", bus_wdata, m_wdata);
      end
    end
  endtask

  // Clock edge: advance the model with the inputs that were just sampled.
  task automatic advance();
    bit who;
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_acc = 0; m_last = 0;
    end else if (!m_valid) begin
      if (inst_req || data_req) begin
        if (inst_req && data_req) begin
`ifdef ARB_RR_EN
          who = !m_last;
`else
          who = 1'b1;
`endif
        end else begin
          who = data_req;
        end
        m_valid = 1; m_acc = 0; m_who = who; m_last = who;
        m_wr    = who ? data_wr    : 1'b0;
        m_wstrb = who ? data_wstrb : '0;
        m_addr  = who ? data_addr  : inst_addr;
        m_wdata = who ? data_wdata : '0;
      end
    end else if (!m_acc) begin
      if (bus_addr_ok) m_acc = 1;
    end else if (bus_data_ok) begin
      m_valid = 0;
    end
    #1;
  endtask

  task automatic tick();
    settle();
    advance();
  endtask

  task automatic do_reset();
    rst = 1; inst_req = 0; inst_addr = '0; data_req = 0; data_wr = 0;
    data_wstrb = '0; data_addr = '0; data_wdata = '0;
    bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
    tick(); tick();
    rst = 0;
  endtask

  // Wait for bus_req, then accept after a_dly cycles and complete after d_dly more.
  task automatic serve(input int a_dly, input int d_dly, output logic [AW-1:0] seen, output int waited);
    bit got = 0;
    seen = '0; waited = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      settle();
      if (bus_req === 1'b1) got = 1;
      else begin advance(); waited++; end
    end
    chk("serve_timeout", got, 1'b1);
    seen = bus_addr;
    advance();
    repeat (a_dly) tick();
    bus_addr_ok = 1; tick(); bus_addr_ok = 0;
    repeat (d_dly) tick();
    bus_data_ok = 1; bus_rdata = $urandom; tick(); bus_data_ok = 0;
  endtask

  logic [AW-1:0] seen;
  int            waited;
  logic [AW-1:0] order [3];
  logic [AW-1:0] exp_order [3];
  logic [AW-1:0] held_addr;

  initial begin
    rst = 1;
    do_reset();

    // Reset values
    settle();
    chk("rst_bus_req", bus_req, 1'b0);
    chk("rst_bus_wr", bus_wr, 1'b0);
    chk("rst_bus_wstrb", bus_wstrb, '0);
    chk("rst_bus_addr", bus_addr, '0);
    chk("rst_bus_wdata", bus_wdata, '0);
    advance();

    // Single fetch with literal timeline
    inst_req = 1; inst_addr = 32'hBFC00000;
    settle(); chk("f0_bus_req", bus_req, 1'b0); advance();
    settle(); chk("f1_bus_req", bus_req, 1'b1); chk("f1_addr", bus_addr, 32'hBFC00000); advance();
    bus_addr_ok = 1;
    settle(); chk("f2_bus_req", bus_req, 1'b1); chk("f2_inst_addr_ok", inst_addr_ok, 1'b1); advance();
    bus_addr_ok = 0;
    settle(); chk("f3_bus_req", bus_req, 1'b0); chk("f3_inst_data_ok", inst_data_ok, 1'b0); advance();
    bus_data_ok = 1; bus_rdata = 32'h24080001;
    settle();
    chk("f4_inst_data_ok", inst_data_ok, 1'b1);
    chk("f4_inst_rdata", inst_rdata, 32'h24080001);
    chk("f4_stall", stallreq_for_bus, 1'b0);
    advance();
    bus_data_ok = 0; inst_req = 0;
    tick();

    // Tie: data first, fetch granted right after data completes
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000;
    data_req = 1; data_addr = 32'h80000100;
    serve(0, 0, seen, waited);
    chk("tie_first", seen, 32'h80000100);
    data_req = 0;
    settle(); chk("tie_gap_bus_req", bus_req, 1'b0); advance();
    serve(1, 1, seen, waited);
    chk("tie_second", seen, 32'hBFC00000);
    chk("tie_second_wait", waited, 0);
    inst_req = 0;
    tick();

    // Three back-to-back ties
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00000;
    data_req = 1; data_addr = 32'h80000100;
    for (int i = 0; i < 3; i++) serve(0, 0, order[i], waited);
    inst_req = 0; data_req = 0;
`ifdef ARB_RR_EN
    exp_order[0] = 32'h80000100; exp_order[1] = 32'hBFC00000; exp_order[2] = 32'h80000100;
`else
    exp_order[0] = 32'h80000100; exp_order[1] = 32'h80000100; exp_order[2] = 32'h80000100;
`endif
    for (int i = 0; i < 3; i++) chk("tie_order", order[i], exp_order[i]);
    tick();

    // Store held stable through ADDR
    do_reset();
    data_req = 1; data_wr = 1; data_wstrb = 4'h3; data_wdata = 32'h0000BEEF; data_addr = 32'h80000200;
    tick();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_bus_wr", bus_wr, 1'b1);
      chk("st_bus_wstrb", bus_wstrb, 4'h3);
      chk("st_bus_wdata", bus_wdata, 32'h0000BEEF);
      advance();
    end
    bus_addr_ok = 1; tick(); bus_addr_ok = 0;
    bus_data_ok = 1; tick(); bus_data_ok = 0;
    data_req = 0; data_wr = 0;
    tick();

    // Reset while in DATA
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00010;
    tick(); tick();
    bus_addr_ok = 1; tick(); bus_addr_ok = 0;
    rst = 1; inst_req = 0;
    tick();
    rst = 0; bus_data_ok = 1;
    settle();
    chk("rd_inst_data_ok", inst_data_ok, 1'b0);
    chk("rd_data_data_ok", data_data_ok, 1'b0);
    chk("rd_bus_req", bus_req, 1'b0);
    advance();
    bus_data_ok = 0;
    tick();

    // Slow bus
    do_reset();
    inst_req = 1; inst_addr = 32'hBFC00040; held_addr = 32'hBFC00040;
    tick();
    for (int i = 0; i < 5; i++) begin
      settle();
      chk("slow_bus_req", bus_req, 1'b1);
      chk("slow_bus_addr", bus_addr, held_addr);
      chk("slow_stall", stallreq_for_bus, 1'b1);
      advance();
    end
    bus_addr_ok = 1; tick(); bus_addr_ok = 0;
    bus_data_ok = 1; tick(); bus_data_ok = 0;
    inst_req = 0;
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      settle();
      advance();
      rst = ($urandom_range(0, 599) == 0);
      if (inst_req) begin
        if (e_inst_done) begin
          inst_req = $urandom_range(0, 1); inst_addr = $urandom & ~32'h3;
        end else if (!(m_valid && !m_who) && $urandom_range(0, 19) == 0) begin
          inst_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        inst_req = 1; inst_addr = $urandom & ~32'h3;
      end
      if (data_req) begin
        if (e_data_done) begin
          data_req = $urandom_range(0, 1); data_wr = $urandom_range(0, 1);
          data_wstrb = SW'($urandom); data_addr = $urandom; data_wdata = $urandom;
        end else if (!(m_valid && m_who) && $urandom_range(0, 19) == 0) begin
          data_req = 0;
        end
      end else if ($urandom_range(0, 2) == 0) begin
        data_req = 1; data_wr = $urandom_range(0, 1);
        data_wstrb = SW'($urandom); data_addr = $urandom; data_wdata = $urandom;
      end
      bus_addr_ok = ($urandom_range(0, 2) == 0);
      bus_data_ok = ($urandom_range(0, 2) == 0);
      bus_rdata   = $urandom;
    end
    rst = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
